// File: rtl/dna_reader_pkg.sv
// Shared constants, state encoding and op-bit positions for the device DNA readout sequencer.
// The parent's CPU write decoder and parallel-port read mux import these too.
package dna_reader_pkg;

  localparam int DNA_BITS_DEF    = 57;
  localparam int CLK_DIV_DEFAULT = 2;
  localparam int PIDX_W          = 6;
  localparam int PHASE_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dna_state_e;

  // Bit positions within the CPU control write that raise start/abort.
  localparam int DNA_START = 0;
  localparam int DNA_ABORT = 1;

  localparam logic [1:0] GET_DNA0 = 2'd0;
  localparam logic [1:0] GET_DNA1 = 2'd1;
  localparam logic [1:0] GET_DNA2 = 2'd2;
  localparam logic [1:0] GET_DNA3 = 2'd3;

  function automatic logic [15:0] dna_word(input logic [63:0] ext, input logic [1:0] sel);
    logic [15:0] w;
    case (sel)
      GET_DNA0: w = ext[15:0];
      GET_DNA1: w = ext[31:16];
      GET_DNA2: w = ext[47:32];
      default:  w = ext[63:48];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dna_reader.sv
// Hardware sequencer for the DNA_PORT primitive: reads the device DNA MSB-first and
// exposes it as a parallel word plus a registered 16-bit slice for the CPU read mux.
module dna_reader
  import dna_reader_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int DNA_BITS = DNA_BITS_DEF
) (
  input  logic                cpu_clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          rd_word,
  input  logic                dna_dout,
  output logic                dna_clk,
  output logic                dna_read,
  output logic                dna_shift,
  output logic                busy,
  output logic                valid,
  output logic [DNA_BITS-1:0] dna_value,
  output logic [15:0]         rd_data
);

  localparam logic [PHASE_W-1:0] PH_HALF = PHASE_W'(CLK_DIV);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(2 * CLK_DIV - 1);
  localparam logic [PIDX_W-1:0]  P_LAST  = PIDX_W'(DNA_BITS - 1);

  dna_state_e          state_q, state_d;
  logic [PIDX_W-1:0]   p_q, p_d;
  logic [PHASE_W-1:0]  ph_q, ph_d;
  logic [DNA_BITS-1:0] value_q, value_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                dclk_q, dclk_d;
  logic                dread_q, dread_d;
  logic                dshift_q, dshift_d;
  logic [15:0]         rd_data_q, rd_data_d;
  logic [63:0]         value_ext;
  logic                run_d;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    ph_d    = ph_q;
    value_d = value_q;
    valid_d = valid_q;

    case (state_q)
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          p_d     = '0;
          ph_d    = '0;
        end else if (ph_q == PH_LAST) begin
          // DOUT has been stable since the rising dna_clk edge mid-period.
          value_d = {value_q[DNA_BITS-2:0], dna_dout};
          ph_d    = '0;
          if (p_q == P_LAST) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            p_d     = '0;
          end else begin
            p_d = p_q + PIDX_W'(1);
          end
        end else begin
          ph_d = ph_q + PHASE_W'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = ST_RUN;
          valid_d = 1'b0;
          value_d = '0;
          p_d     = '0;
          ph_d    = '0;
        end
      end
    endcase

    // Port controls are decoded from the next state so every output is a flop.
    run_d    = (state_d == ST_RUN);
    busy_d   = run_d;
    dclk_d   = run_d && (ph_d >= PH_HALF);
    dread_d  = run_d && (p_d == '0);
    dshift_d = run_d && (p_d != '0);

    value_ext                 = '0;
    value_ext[DNA_BITS-1:0]   = value_q;
    rd_data_d                 = dna_word(value_ext, rd_word);
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      p_q       <= '0;
      ph_q      <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      dclk_q    <= 1'b0;
      dread_q   <= 1'b0;
      dshift_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      ph_q      <= ph_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      dclk_q    <= dclk_d;
      dread_q   <= dread_d;
      dshift_q  <= dshift_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign dna_clk   = dclk_q;
  assign dna_read  = dread_q;
  assign dna_shift = dshift_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign dna_value = value_q;
  assign rd_data   = rd_data_q;

endmodule
